rgb_pwm_fader: RTL and testbench
================================

Name: rgb_pwm_fader

Overview:
Drives the pico-ice RGB LED pins with 8-bit per-channel PWM, replacing raw counter-bit blinking with controlled colour and brightness. Upstream logic (clock/nixie controller) issues colour commands over a valid/ready handshake. Each command either applies immediately or fades linearly. Duty changes take effect only at PWM frame boundaries, so output is glitch-free.

Parameters:
PRESCALE, 47, clk cycles per PWM step minus 1 (12 MHz/48/256 ≈ 977 Hz frame)
FADE_FRAMES, 4, PWM frames per ±1 fade step (range 1..255)
ACTIVE_LOW, 0, 1 = LED pins are on when driven low

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_red  in  8  target red duty (0..255)
cmd_green  in  8  target green duty
cmd_blue  in  8  target blue duty
cmd_fade  in  1  1 = fade to target, 0 = apply at next frame
led_red  out  1  PWM output, registered
led_green  out  1  PWM output, registered
led_blue  out  1  PWM output, registered
busy  out  1  command in progress (not IDLE)
frame_tick  out  1  1-cycle pulse at each PWM frame boundary

Behaviour:
- Reset: prescaler=0, pwm_cnt=0, current=target=0 for all channels, state IDLE. Outputs: led_*=ACTIVE_LOW (off), cmd_ready=0 while rst high, busy=0, frame_tick=0. cmd_ready=1 on the first cycle after rst deasserts.
- Prescaler counts 0..PRESCALE and wraps. step pulse fires when prescaler==PRESCALE. pwm_cnt (8 bit) increments on step and wraps 255->0.
- Frame boundary: the step on which pwm_cnt wraps 255->0. frame_tick is asserted in the same cycle that pwm_cnt becomes 0.
- Output: led_x <= (pwm_cnt < current_x) ^ ACTIVE_LOW, registered, so there is 1 cycle latency from pwm_cnt. Duty 0 gives always off. Duty 255 gives on for 255 of 256 steps.
- current_x changes only at a frame boundary, so there are no partial-frame duty changes.
- Handshake: a command is accepted when cmd_valid && cmd_ready. cmd_ready=1 only in IDLE. The accepted command latches target_x and moves to the next state in the following cycle. cmd_* must be held stable only in the accept cycle.
- States:
  - IDLE: cmd_ready=1, busy=0.
    - Accept with cmd_fade=0 -> APPLY.
    - Accept with cmd_fade=1 -> FADE; fade_cnt=0.
  - APPLY: at the next frame boundary, current<=target, then -> IDLE.
  - FADE: at each frame boundary, fade_cnt increments.
    - When fade_cnt reaches FADE_FRAMES-1: fade_cnt<=0, and each current_x moves 1 toward target_x. A channel that is already equal holds.
    - When all three channels are equal after an update (or already equal on entry, checked at the next boundary) -> IDLE.
- Boundaries:
  - Command accepted in the same cycle as a frame boundary: that boundary is not used. The command applies or steps from the next boundary onward.
  - Fade from 0 to 255 takes 255*FADE_FRAMES frames. Per-channel step arithmetic saturates at 0 and 255, with no wrap.
  - Target equal to current: APPLY and FADE both complete at the next boundary.
  - cmd_valid while busy is ignored and not queued. The sender must hold it until ready.
  - rst during APPLY or FADE aborts the command and restores all reset values in the next cycle. Outputs go off immediately after the reset edge.

Decomposition:
- Package rgb_pwm_pkg holds PWM_BITS=8, the state enum {IDLE, APPLY, FADE}, and the duty type (logic [7:0]).
- Sub-module pwm_channel is instantiated 3x. It contains current/target registers, the saturating ±1 step, the equality flag, and the comparator plus output register.
- The top level holds the prescaler, pwm_cnt, fade_cnt and the FSM.

Test Plan:
1. PRESCALE=0; release rst; hold cmd_valid=0 -> all led_* stay 0 for 2 frames (512 cycles); cmd_ready=1 from the first post-reset cycle; frame_tick every 256 cycles.
2. Immediate cmd R=64,G=0,B=255, fade=0 -> busy until the next frame_tick. Then per frame: led_red high for exactly 64 cycles, led_green never high, led_blue high for 255 cycles. cmd_ready returns to 1 the cycle after the boundary.
3. Fade cmd R=4 from 0, FADE_FRAMES=2 -> current_red reads 1,2,3,4 at boundaries 2,4,6,8 after accept. busy drops after the 8th boundary.
4. Command accepted in the frame_tick cycle, R=10, fade=0 -> duty 10 appears at the following boundary (256 cycles later), not the current one.
5. rst pulsed mid-fade (R at 100 of target 200) -> next cycle: led_*=0, busy=0. After release, cmd_ready=1 and duty 0 persists.
6. ACTIVE_LOW=1, duty 0 then 255 -> led pins held 1 constantly, then low for 255 of 256 cycles per frame. cmd_valid pulsed while busy is ignored, confirmed by unchanged target.

Source files
------------

// File: rtl/rgb_pwm_pkg.sv
// Shared types for the RGB PWM fader.
//   PWM_BITS    : width of duty values and of the PWM step counter
//   duty_t      : one channel's duty / target value
//   state_t     : command FSM states
//   step_toward : one saturating +/-1 step of a duty value toward a target
package rgb_pwm_pkg;

  localparam int PWM_BITS = 8;

  typedef logic [PWM_BITS-1:0] duty_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    FADE  = 2'd2
  } state_t;

  // Moves cur by one toward tgt; never wraps past 0 or full scale.
  function automatic duty_t step_toward(input duty_t cur, input duty_t tgt);
    duty_t res;
    res = cur;
    if ((cur < tgt) && (cur != '1))
      res = cur + duty_t'(1);
    else if ((cur > tgt) && (cur != '0))
      res = cur - duty_t'(1);
    return res;
  endfunction

endpackage

// File: rtl/rgb_pwm_fader_if.sv
// Colour command channel between the upstream controller and the fader.
//   cmd_valid / cmd_ready : valid/ready handshake
//   cmd_red/green/blue    : target duty per channel
//   cmd_fade              : 1 = fade linearly, 0 = apply at next frame
// master = command sender, slave = rgb_pwm_fader.
interface rgb_pwm_fader_if
  import rgb_pwm_pkg::*;
  ();

  logic  cmd_valid;
  logic  cmd_ready;
  duty_t cmd_red;
  duty_t cmd_green;
  duty_t cmd_blue;
  logic  cmd_fade;

  modport master (
    output cmd_valid, cmd_red, cmd_green, cmd_blue, cmd_fade,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_red, cmd_green, cmd_blue, cmd_fade,
    output cmd_ready
  );

endinterface

// File: rtl/pwm_channel.sv
// One colour channel: target and current duty registers, the saturating
// fade step, equality flags for the FSM, and the registered PWM output.
//   load/target_in : latch a new target (command accept)
//   apply          : current <= target (frame boundary in APPLY)
//   step           : current moves one toward target (fade step)
//   pwm_cnt        : shared PWM step counter
//   led            : registered PWM pin, ACTIVE_LOW selects polarity
//   at_target      : current == target now
//   at_target_next : current would equal target after one step
module pwm_channel
  import rgb_pwm_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  duty_t target_in,
  input  logic  apply,
  input  logic  step,
  input  duty_t pwm_cnt,
  output logic  led,
  output logic  at_target,
  output logic  at_target_next
);

  duty_t current;
  duty_t target;
  duty_t stepped;

  assign stepped        = step_toward(current, target);
  assign at_target      = (current == target);
  assign at_target_next = (stepped == target);

  always_ff @(posedge clk) begin
    if (rst) begin
      current <= '0;
      target  <= '0;
      led     <= ACTIVE_LOW;
    end else begin
      if (load)
        target <= target_in;
      // apply and step are only ever raised on frame boundaries, which keeps
      // every frame at a single duty.
      if (apply)
        current <= target;
      else if (step)
        current <= stepped;
      led <= (pwm_cnt < current) ^ ACTIVE_LOW;
    end
  end

endmodule

// File: rtl/rgb_pwm_fader.sv
// RGB LED PWM driver with immediate or linearly faded colour changes.
//   clk, rst     : clock, synchronous active-high reset
//   cmd          : colour command channel (slave side)
//   led_*        : registered PWM pins
//   busy         : a command is in progress
//   frame_tick   : one-cycle pulse in the cycle pwm_cnt becomes 0
// Parameters: PRESCALE (clk cycles per PWM step minus 1), FADE_FRAMES
// (frames per +/-1 fade step, 1..255), ACTIVE_LOW (pin polarity).
//
// state | meaning
// IDLE  | ready for a command
// APPLY | wait for next frame boundary, then current <= target
// FADE  | every FADE_FRAMES boundaries step current toward target
module rgb_pwm_fader
  import rgb_pwm_pkg::*;
#(
  parameter int PRESCALE    = 47,
  parameter int FADE_FRAMES = 4,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  rgb_pwm_fader_if.slave cmd,
  output logic           led_red,
  output logic           led_green,
  output logic           led_blue,
  output logic           busy,
  output logic           frame_tick
);

  localparam int PS_W = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  localparam logic [7:0] FADE_LAST = 8'(FADE_FRAMES - 1);

  logic [PS_W-1:0] prescaler;
  duty_t           pwm_cnt;
  logic [7:0]      fade_cnt;
  state_t          state;

  logic       pwm_step;
  logic       boundary;
  logic       accept;
  logic       apply;
  logic       fade_step;
  logic [2:0] eq_now;
  logic [2:0] eq_next;

  assign pwm_step  = (prescaler == PS_W'(PRESCALE));
  assign boundary  = pwm_step && (pwm_cnt == '1);
  assign accept    = cmd.cmd_valid && cmd.cmd_ready;
  assign apply     = (state == APPLY) && boundary;
  assign fade_step = (state == FADE) && boundary && (fade_cnt == FADE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler  <= '0;
      pwm_cnt    <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= boundary;
      if (pwm_step) begin
        prescaler <= '0;
        pwm_cnt   <= pwm_cnt + duty_t'(1);
      end else begin
        prescaler <= prescaler + PS_W'(1);
      end
    end
  end

  // The boundary in the accept cycle is seen while still in IDLE, so a new
  // command always acts from the following boundary onward.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      fade_cnt      <= '0;
      cmd.cmd_ready <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cmd.cmd_ready <= 1'b1;
          busy          <= 1'b0;
          if (accept) begin
            state         <= cmd.cmd_fade ? FADE : APPLY;
            fade_cnt      <= '0;
            cmd.cmd_ready <= 1'b0;
            busy          <= 1'b1;
          end
        end
        APPLY: begin
          if (boundary) begin
            state         <= IDLE;
            cmd.cmd_ready <= 1'b1;
            busy          <= 1'b0;
          end
        end
        FADE: begin
          if (boundary) begin
            if (&eq_now) begin
              state         <= IDLE;
              cmd.cmd_ready <= 1'b1;
              busy          <= 1'b0;
            end else if (fade_cnt == FADE_LAST) begin
              fade_cnt <= '0;
              if (&eq_next) begin
                state         <= IDLE;
                cmd.cmd_ready <= 1'b1;
                busy          <= 1'b0;
              end
            end else begin
              fade_cnt <= fade_cnt + 8'd1;
            end
          end
        end
        default: begin
          state         <= IDLE;
          cmd.cmd_ready <= 1'b1;
          busy          <= 1'b0;
        end
      endcase
    end
  end

  pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_red (
    .clk            (clk),
    .rst            (rst),
    .load           (accept),
    .target_in      (cmd.cmd_red),
    .apply          (apply),
    .step           (fade_step),
    .pwm_cnt        (pwm_cnt),
    .led            (led_red),
    .at_target      (eq_now[0]),
    .at_target_next (eq_next[0])
  );

  pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_green (
    .clk            (clk),
    .rst            (rst),
    .load           (accept),
    .target_in      (cmd.cmd_green),
    .apply          (apply),
    .step           (fade_step),
    .pwm_cnt        (pwm_cnt),
    .led            (led_green),
    .at_target      (eq_now[1]),
    .at_target_next (eq_next[1])
  );

  pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_blue (
    .clk            (clk),
    .rst            (rst),
    .load           (accept),
    .target_in      (cmd.cmd_blue),
    .apply          (apply),
    .step           (fade_step),
    .pwm_cnt        (pwm_cnt),
    .led            (led_blue),
    .at_target      (eq_now[2]),
    .at_target_next (eq_next[2])
  );

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Bench for rgb_pwm_fader: two instances (active-high, fast prescale, two
// frames per fade step; active-low, prescale 1, one frame per fade step).
// Each command pushes the expected per-frame duties; a monitor measures the
// on-time of every PWM frame and compares it against the queue head.
module tb_rgb_pwm_fader;
  import rgb_pwm_pkg::*;

  localparam int P0 = 0;
  localparam int F0 = 2;
  localparam bit AL0 = 1'b0;
  localparam int P1 = 1;
  localparam int F1 = 1;
  localparam bit AL1 = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rgb_pwm_fader_if if_a ();
  rgb_pwm_fader_if if_b ();

  logic [1:0] led_r, led_g, led_b, busy, tick, rdy;
  assign rdy[0] = if_a.cmd_ready;
  assign rdy[1] = if_b.cmd_ready;

  rgb_pwm_fader #(.PRESCALE(P0), .FADE_FRAMES(F0), .ACTIVE_LOW(AL0)) dut_a (
    .clk(clk), .rst(rst), .cmd(if_a),
    .led_red(led_r[0]), .led_green(led_g[0]), .led_blue(led_b[0]),
    .busy(busy[0]), .frame_tick(tick[0])
  );

  rgb_pwm_fader #(.PRESCALE(P1), .FADE_FRAMES(F1), .ACTIVE_LOW(AL1)) dut_b (
    .clk(clk), .rst(rst), .cmd(if_b),
    .led_red(led_r[1]), .led_green(led_g[1]), .led_blue(led_b[1]),
    .busy(busy[1]), .frame_tick(tick[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic [23:0] exp_q0[$];
  logic [23:0] exp_q1[$];
  int cur_m[2][3];
  int on_cnt[2][3];
  bit have_start[2];

  function automatic bit al(input int i);
    return (i == 0) ? AL0 : AL1;
  endfunction

  function automatic int steps_per_frame(input int i);
    return (i == 0) ? (P0 + 1) : (P1 + 1);
  endfunction

  function automatic int qsize(input int i);
    return (i == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic void push_exp(input int i, input int r, input int g, input int b);
    logic [23:0] e;
    e = {8'(r), 8'(g), 8'(b)};
    if (i == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endfunction

  // Pushes the in-flight frame (old duty), then one entry per frame until the
  // command completes, then one hold frame. Returns boundaries until idle.
  function automatic int push_sequence(input int i, input int r, input int g,
                                       input int b, input bit fade);
    int tgt[3];
    int v[3];
    int d, k, maxd, n, ff;
    tgt = '{r, g, b};
    ff = (i == 0) ? F0 : F1;
    push_exp(i, cur_m[i][0], cur_m[i][1], cur_m[i][2]);
    if (!fade) begin
      n = 1;
      push_exp(i, r, g, b);
    end else begin
      maxd = 0;
      for (int c = 0; c < 3; c++) begin
        d = (tgt[c] > cur_m[i][c]) ? tgt[c] - cur_m[i][c] : cur_m[i][c] - tgt[c];
        if (d > maxd) maxd = d;
      end
      n = (maxd == 0) ? 1 : maxd * ff;
      for (int j = 1; j <= n; j++) begin
        for (int c = 0; c < 3; c++) begin
          d = (tgt[c] > cur_m[i][c]) ? tgt[c] - cur_m[i][c] : cur_m[i][c] - tgt[c];
          k = j / ff;
          if (k > d) k = d;
          v[c] = (tgt[c] > cur_m[i][c]) ? cur_m[i][c] + k : cur_m[i][c] - k;
        end
        push_exp(i, v[0], v[1], v[2]);
      end
    end
    push_exp(i, r, g, b);
    for (int c = 0; c < 3; c++) cur_m[i][c] = tgt[c];
    return n;
  endfunction

  task automatic finish_window(input int i);
    logic [23:0] e;
    int ps;
    if (qsize(i) == 0) return;
    if (i == 0) e = exp_q0.pop_front();
    else e = exp_q1.pop_front();
    ps = steps_per_frame(i);
    check_val($sformatf("duty%0d_red", i), on_cnt[i][0], int'(e[23:16]) * ps);
    check_val($sformatf("duty%0d_green", i), on_cnt[i][1], int'(e[15:8]) * ps);
    check_val($sformatf("duty%0d_blue", i), on_cnt[i][2], int'(e[7:0]) * ps);
  endtask

  // Frame window is (tick, next tick]: led lags pwm_cnt by one cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          have_start[i] = 1'b0;
          for (int c = 0; c < 3; c++) on_cnt[i][c] = 0;
        end else begin
          on_cnt[i][0] += int'(led_r[i] ^ al(i));
          on_cnt[i][1] += int'(led_g[i] ^ al(i));
          on_cnt[i][2] += int'(led_b[i] ^ al(i));
          if (tick[i]) begin
            if (have_start[i]) finish_window(i);
            have_start[i] = 1'b1;
            for (int c = 0; c < 3; c++) on_cnt[i][c] = 0;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input bit v, input int r, input int g,
                       input int b, input bit f);
    if (i == 0) begin
      if_a.cmd_valid = v; if_a.cmd_red = 8'(r); if_a.cmd_green = 8'(g);
      if_a.cmd_blue = 8'(b); if_a.cmd_fade = f;
    end else begin
      if_b.cmd_valid = v; if_b.cmd_red = 8'(r); if_b.cmd_green = 8'(g);
      if_b.cmd_blue = 8'(b); if_b.cmd_fade = f;
    end
  endtask

  task automatic wait_tick(input int i, output int cycles);
    cycles = 0;
    do begin
      cyc();
      cycles++;
    end while (!tick[i] && cycles < 2000);
    check_val($sformatf("tick_seen%0d", i), int'(tick[i]), 1);
  endtask

  task automatic send_cmd(input int i, input int r, input int g, input int b,
                          input bit fade, output int nb);
    drive(i, 1'b1, r, g, b, fade);
    check_val($sformatf("ready_idle%0d", i), int'(rdy[i]), 1);
    cyc();
    drive(i, 1'b0, r, g, b, fade);
    check_val($sformatf("busy_after_accept%0d", i), int'(busy[i]), 1);
    check_val($sformatf("ready_after_accept%0d", i), int'(rdy[i]), 0);
    nb = push_sequence(i, r, g, b, fade);
  endtask

  task automatic wait_idle(input int i, input int nb, input string tag);
    int ticks, n, limit;
    ticks = 0;
    n = 0;
    limit = (nb + 2) * 256 * steps_per_frame(i);
    while (busy[i] && n < limit) begin
      cyc();
      n++;
      if (tick[i]) ticks++;
    end
    check_val({tag, "_frames"}, ticks, nb);
    check_val({tag, "_ready"}, int'(rdy[i]), 1);
  endtask

  task automatic drain(input int i);
    int n;
    n = 0;
    while (qsize(i) != 0 && n < 4 * 256 * steps_per_frame(i)) begin
      cyc();
      n++;
    end
    check_val($sformatf("drain%0d", i), qsize(i), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, nb;
    drive(0, 1'b0, 0, 0, 0, 1'b0);
    drive(1, 1'b0, 0, 0, 0, 1'b0);
    cyc(); cyc(); cyc();

    check_val("rst_led_a", int'(led_r[0] | led_g[0] | led_b[0]), 0);
    check_val("rst_led_b", int'(led_r[1] & led_g[1] & led_b[1]), 1);
    check_val("rst_ready", int'(rdy), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_tick", int'(tick), 0);

    rst = 1'b0;
    cyc();
    check_val("ready_post_rst", int'(rdy), 3);
    push_exp(0, 0, 0, 0);
    push_exp(0, 0, 0, 0);
    wait_tick(0, c);
    wait_tick(0, c);
    check_val("frame_len_a", c, 256);
    drain(0);

    // linear fade, two frames per step
    wait_tick(0, c);
    cyc(); cyc();
    send_cmd(0, 4, 0, 2, 1'b1, nb);
    check_val("fade4_model", nb, 8);
    wait_idle(0, nb, "fade4");
    drain(0);

    // immediate apply
    wait_tick(0, c);
    repeat (5) cyc();
    send_cmd(0, 64, 0, 255, 1'b0, nb);
    wait_idle(0, nb, "apply");
    drain(0);

    // target already equal: both kinds finish at the next boundary
    wait_tick(0, c);
    repeat (3) cyc();
    send_cmd(0, 64, 0, 255, 1'b0, nb);
    wait_idle(0, nb, "apply_eq");
    drain(0);
    wait_tick(0, c);
    repeat (3) cyc();
    send_cmd(0, 64, 0, 255, 1'b1, nb);
    wait_idle(0, nb, "fade_eq");
    drain(0);

    // accepted in the frame_tick cycle
    wait_tick(0, c);
    send_cmd(0, 10, 0, 255, 1'b0, nb);
    wait_idle(0, nb, "apply_on_tick");
    drain(0);

    // reset mid-fade
    wait_tick(0, c);
    send_cmd(0, 20, 5, 250, 1'b1, nb);
    repeat (6) wait_tick(0, c);
    repeat (7) cyc();
    exp_q0.delete();
    exp_q1.delete();
    rst = 1'b1;
    cyc();
    check_val("midrst_led_a", int'(led_r[0] | led_g[0] | led_b[0]), 0);
    check_val("midrst_busy_a", int'(busy[0]), 0);
    check_val("midrst_ready_a", int'(rdy[0]), 0);
    check_val("midrst_led_b", int'(led_r[1] & led_g[1] & led_b[1]), 1);
    rst = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 3; k++) cur_m[i][k] = 0;
    cyc();
    check_val("ready_post_midrst", int'(rdy), 3);
    push_exp(0, 0, 0, 0);
    push_exp(0, 0, 0, 0);
    drain(0);

    // active-low instance
    wait_tick(1, c);
    wait_tick(1, c);
    check_val("frame_len_b", c, 512);
    send_cmd(1, 0, 0, 0, 1'b0, nb);
    wait_idle(1, nb, "al_zero");
    drain(1);

    wait_tick(1, c);
    repeat (4) cyc();
    send_cmd(1, 255, 128, 1, 1'b0, nb);
    drive(1, 1'b1, 7, 7, 7, 1'b0);
    cyc();
    check_val("ignored_ready", int'(rdy[1]), 0);
    drive(1, 1'b0, 7, 7, 7, 1'b0);
    wait_idle(1, nb, "al_full");
    drain(1);

    wait_tick(1, c);
    repeat (9) cyc();
    send_cmd(1, 250, 130, 0, 1'b1, nb);
    check_val("fade_down_model", nb, 5);
    wait_idle(1, nb, "al_fade");
    drain(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
